// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the hazard unit: forward selects, FSM states and
// the operand-forwarding priority helper.
package pipeline_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hazard_state_t;

    // The younger producer (Memory) holds the newer value, so it wins over Writeback.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] m_wa,
        input logic              m_we,
        input logic [REG_AW-1:0] w_wa,
        input logic              w_we
    );
        if (m_we && (m_wa != '0) && (m_wa == src)) begin
            return FWD_M;
        end
        if (w_we && (w_wa != '0) && (w_wa == src)) begin
            return FWD_W;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. master = pipeline side, slave = hazard unit.
interface hazard_unit_if
    import pipeline_pkg::*;
#(
    parameter int PERF_W = 32
);

    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [REG_AW-1:0] e_rs;
    logic [REG_AW-1:0] e_rt;
    logic [REG_AW-1:0] e_rf_wa;
    logic              e_rf_we;
    logic              e_load;
    logic [REG_AW-1:0] m_rf_wa;
    logic              m_rf_we;
    logic [REG_AW-1:0] w_rf_wa;
    logic              w_rf_we;
    logic              m_branch_taken;
    logic              e_mdu_start;
    logic              mdu_done;

    logic              f_stall;
    logic              d_stall;
    logic              e_stall;
    logic              d_flush;
    logic              e_flush;
    logic              m_flush;
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic              mdu_abort;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    modport master (
        output d_rs, d_rt, e_rs, e_rt, e_rf_wa, e_rf_we, e_load,
               m_rf_wa, m_rf_we, w_rf_wa, w_rf_we,
               m_branch_taken, e_mdu_start, mdu_done,
        input  f_stall, d_stall, e_stall, d_flush, e_flush, m_flush,
               fwd_a_e, fwd_b_e, mdu_abort, stall_cnt, flush_cnt
    );

    modport slave (
        input  d_rs, d_rt, e_rs, e_rt, e_rf_wa, e_rf_we, e_load,
               m_rf_wa, m_rf_we, w_rf_wa, w_rf_we,
               m_branch_taken, e_mdu_start, mdu_done,
        output f_stall, d_stall, e_stall, d_flush, e_flush, m_flush,
               fwd_a_e, fwd_b_e, mdu_abort, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_perf_counter.sv
// PERF_W-wide event counter that sticks at all-ones instead of wrapping.
module hazard_perf_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_inc,
    output logic [PERF_W-1:0] o_count
);

    logic [PERF_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + PERF_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and MDU wait FSM.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input logic          clock,
    input logic          reset,
    hazard_unit_if.slave hz
);

    hazard_state_t r_state;
    hazard_state_t w_next_state;
    fwd_sel_t      w_fwd_a;
    fwd_sel_t      w_fwd_b;
    logic          w_load_use;
    logic          w_f_stall;
    logic          w_d_stall;
    logic          w_e_stall;
    logic          w_d_flush;
    logic          w_e_flush;
    logic          w_m_flush;
    logic          w_mdu_abort;

    assign w_fwd_a = fwd_select(hz.e_rs, hz.m_rf_wa, hz.m_rf_we, hz.w_rf_wa, hz.w_rf_we);
    assign w_fwd_b = fwd_select(hz.e_rt, hz.m_rf_wa, hz.m_rf_we, hz.w_rf_wa, hz.w_rf_we);

    assign w_load_use = hz.e_load && hz.e_rf_we && (hz.e_rf_wa != '0) &&
                        ((hz.e_rf_wa == hz.d_rs) || (hz.e_rf_wa == hz.d_rt));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_f_stall    = 1'b0;
        w_d_stall    = 1'b0;
        w_e_stall    = 1'b0;
        w_d_flush    = 1'b0;
        w_e_flush    = 1'b0;
        w_m_flush    = 1'b0;
        w_mdu_abort  = 1'b0;
        unique case (r_state)
            RUN: begin
                if (hz.m_branch_taken) begin
                    w_d_flush   = 1'b1;
                    w_e_flush   = 1'b1;
                    w_m_flush   = 1'b1;
                    w_mdu_abort = hz.e_mdu_start;
                end else if (hz.e_mdu_start && !hz.mdu_done) begin
                    // The MDU hold freezes E, so it takes precedence over a load-use bubble.
                    w_f_stall    = 1'b1;
                    w_d_stall    = 1'b1;
                    w_e_stall    = 1'b1;
                    w_m_flush    = 1'b1;
                    w_next_state = MDU_WAIT;
                end else if (w_load_use) begin
                    w_f_stall = 1'b1;
                    w_d_stall = 1'b1;
                    w_e_flush = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (hz.m_branch_taken) begin
                    w_d_flush    = 1'b1;
                    w_e_flush    = 1'b1;
                    w_m_flush    = 1'b1;
                    w_mdu_abort  = 1'b1;
                    w_next_state = RUN;
                end else if (!hz.mdu_done) begin
                    w_f_stall = 1'b1;
                    w_d_stall = 1'b1;
                    w_e_stall = 1'b1;
                    w_m_flush = 1'b1;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    // Reset forces every control output quiet regardless of the inputs.
    assign hz.f_stall   = w_f_stall   & ~reset;
    assign hz.d_stall   = w_d_stall   & ~reset;
    assign hz.e_stall   = w_e_stall   & ~reset;
    assign hz.d_flush   = w_d_flush   & ~reset;
    assign hz.e_flush   = w_e_flush   & ~reset;
    assign hz.m_flush   = w_m_flush   & ~reset;
    assign hz.mdu_abort = w_mdu_abort & ~reset;
    assign hz.fwd_a_e   = reset ? FWD_NONE : w_fwd_a;
    assign hz.fwd_b_e   = reset ? FWD_NONE : w_fwd_b;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_f_stall),
        .o_count (hz.stall_cnt)
    );

    hazard_perf_counter #(.PERF_W(PERF_W)) u_flush_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (hz.m_branch_taken),
        .o_count (hz.flush_cnt)
    );
`else
    assign hz.stall_cnt = {PERF_W{1'b0}};
    assign hz.flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// against a rule-level reference model. Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_unit;
    import pipeline_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif
    localparam int SAT_W = 3;

    typedef struct {
        logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
        logic       e_we, e_load, m_we, w_we, br, start, done, rst;
    } stim_t;

    typedef struct {
        logic       f_stall, d_stall, e_stall, d_flush, e_flush, m_flush, abort;
        logic [1:0] fa, fb;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hazard_unit_if #(.PERF_W(32))    hz ();
    hazard_unit_if #(.PERF_W(SAT_W)) sz ();

    hazard_unit #(.PERF_W(32)) u_dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz.slave)
    );

    hazard_unit #(.PERF_W(SAT_W)) u_sat (
        .clock (clock),
        .reset (reset),
        .hz    (sz.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: "an MDU op is outstanding" plus event tallies.
    bit          mdl_busy = 1'b0;
    longint      mdl_stalls = 0;
    longint      mdl_flushes = 0;
    exp_t        mdl_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Forwarding: scan producers from youngest to oldest, first live match wins.
    function automatic logic [1:0] fwd_ref(input logic [4:0] src, input stim_t s);
        logic [4:0] wa [2];
        logic       we [2];
        logic [1:0] code [2];
        wa[0] = s.m_wa; we[0] = s.m_we; code[0] = 2'b10;
        wa[1] = s.w_wa; we[1] = s.w_we; code[1] = 2'b01;
        for (int i = 0; i < 2; i++) begin
            if (we[i] && wa[i] != 0 && wa[i] == src) return code[i];
        end
        return 2'b00;
    endfunction

    function automatic exp_t predict(input stim_t s, input bit busy);
        exp_t e;
        bit   hold;
        bit   lu;
        e = '{default: '0};
        if (s.rst) return e;
        e.fa = fwd_ref(s.e_rs, s);
        e.fb = fwd_ref(s.e_rt, s);
        hold = busy ? !s.done : (s.start && !s.done);
        lu   = !busy && s.e_load && s.e_we && s.e_wa != 0 && (s.e_wa == s.d_rs || s.e_wa == s.d_rt);
        if (s.br) begin
            {e.d_flush, e.e_flush, e.m_flush} = 3'b111;
            e.abort = busy || s.start;
        end else if (hold) begin
            {e.f_stall, e.d_stall, e.e_stall, e.m_flush} = 4'b1111;
        end else if (lu) begin
            {e.f_stall, e.d_stall, e.e_flush} = 3'b111;
        end
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset             = s.rst;
        hz.d_rs           = s.d_rs;
        hz.d_rt           = s.d_rt;
        hz.e_rs           = s.e_rs;
        hz.e_rt           = s.e_rt;
        hz.e_rf_wa        = s.e_wa;
        hz.e_rf_we        = s.e_we;
        hz.e_load         = s.e_load;
        hz.m_rf_wa        = s.m_wa;
        hz.m_rf_we        = s.m_we;
        hz.w_rf_wa        = s.w_wa;
        hz.w_rf_we        = s.w_we;
        hz.m_branch_taken = s.br;
        hz.e_mdu_start    = s.start;
        hz.mdu_done       = s.done;
    endtask

    // Drive at posedge+1, compare every output at the following negedge.
    task automatic drive_check(input stim_t s, input string tag);
        apply(s);
        #4;
        mdl_exp = predict(s, mdl_busy);
        check({tag, ".f_stall"},   hz.f_stall,   mdl_exp.f_stall);
        check({tag, ".d_stall"},   hz.d_stall,   mdl_exp.d_stall);
        check({tag, ".e_stall"},   hz.e_stall,   mdl_exp.e_stall);
        check({tag, ".d_flush"},   hz.d_flush,   mdl_exp.d_flush);
        check({tag, ".e_flush"},   hz.e_flush,   mdl_exp.e_flush);
        check({tag, ".m_flush"},   hz.m_flush,   mdl_exp.m_flush);
        check({tag, ".mdu_abort"}, hz.mdu_abort, mdl_exp.abort);
        check({tag, ".fwd_a_e"},   hz.fwd_a_e,   mdl_exp.fa);
        check({tag, ".fwd_b_e"},   hz.fwd_b_e,   mdl_exp.fb);
        check({tag, ".stall_cnt"}, hz.stall_cnt, PERF_EN ? mdl_stalls : 0);
        check({tag, ".flush_cnt"}, hz.flush_cnt, PERF_EN ? mdl_flushes : 0);
    endtask

    task automatic tick(input stim_t s);
        @(posedge clock);
        if (s.rst) begin
            mdl_busy    = 1'b0;
            mdl_stalls  = 0;
            mdl_flushes = 0;
        end else begin
            if (mdl_exp.f_stall && mdl_stalls < 64'hFFFF_FFFF) mdl_stalls++;
            if (s.br && mdl_flushes < 64'hFFFF_FFFF) mdl_flushes++;
            if (s.br) mdl_busy = 1'b0;
            else if (mdl_busy) mdl_busy = !s.done;
            else mdl_busy = s.start && !s.done;
        end
        #1;
    endtask

    task automatic step(input stim_t s, input string tag);
        drive_check(s, tag);
        tick(s);
    endtask

    stim_t s;

    initial begin
        apply(idle());
        reset = 1'b1;
        sz.d_rs = '0; sz.d_rt = '0; sz.e_rs = '0; sz.e_rt = '0;
        sz.e_rf_wa = '0; sz.e_rf_we = 1'b0; sz.e_load = 1'b0;
        sz.m_rf_wa = '0; sz.m_rf_we = 1'b0; sz.w_rf_wa = '0; sz.w_rf_we = 1'b0;
        sz.m_branch_taken = 1'b0; sz.e_mdu_start = 1'b0; sz.mdu_done = 1'b0;
        @(posedge clock);
        #1;

        // Reset with matching forwarding inputs: everything must stay quiet.
        s = idle(); s.rst = 1; s.e_rs = 5; s.m_wa = 5; s.m_we = 1;
        drive_check(s, "rst");
        check("rst_fwd_a", hz.fwd_a_e, 2'b00);
        tick(s);

        // Forwarding priority and r0 exclusion.
        s = idle(); s.e_rs = 5; s.m_wa = 5; s.m_we = 1; s.w_wa = 5; s.w_we = 1;
        drive_check(s, "fwd_mw");
        check("fwd_m_wins", hz.fwd_a_e, 2'b10);
        tick(s);
        s.m_we = 0;
        drive_check(s, "fwd_w");
        check("fwd_w_only", hz.fwd_a_e, 2'b01);
        tick(s);
        s.m_we = 1; s.e_rs = 0; s.m_wa = 0; s.w_wa = 0; s.e_rt = 5;
        drive_check(s, "fwd_r0");
        check("fwd_r0_none", hz.fwd_a_e, 2'b00);
        tick(s);

        // Load-use: one bubble cycle, then quiet once E holds the bubble.
        s = idle(); s.e_load = 1; s.e_we = 1; s.e_wa = 8; s.d_rt = 8;
        drive_check(s, "lu");
        check("lu_stall", {hz.f_stall, hz.d_stall, hz.e_flush}, 3'b111);
        tick(s);
        s = idle(); s.d_rt = 8;
        drive_check(s, "lu_after");
        check("lu_after_quiet", {hz.f_stall, hz.d_stall, hz.e_flush}, 3'b000);
        tick(s);

        // MDU: start in cycle 0, done in cycle 4.
        s = idle(); s.rst = 1; step(s, "mdu_rst");
        for (int c = 0; c < 5; c++) begin
            s = idle(); s.start = 1; s.done = (c == 4);
            drive_check(s, $sformatf("mdu_c%0d", c));
            check($sformatf("mdu_e_stall_c%0d", c), hz.e_stall, (c < 4) ? 1'b1 : 1'b0);
            tick(s);
        end
        s = idle();
        drive_check(s, "mdu_c5");
        check("mdu_run_c5", hz.e_stall, 1'b0);
        check("mdu_stall_cnt", hz.stall_cnt, PERF_EN ? 32'd4 : 32'd0);
        tick(s);

        // Zero-latency MDU: no stall, stays in RUN.
        s = idle(); s.start = 1; s.done = 1; step(s, "mdu_zero");
        s = idle(); step(s, "mdu_zero_after");

        // Collision: MDU start + branch + load-use.
        s = idle(); s.rst = 1; step(s, "col_rst");
        s = idle(); s.start = 1; s.br = 1; s.e_load = 1; s.e_we = 1; s.e_wa = 3; s.d_rs = 3;
        drive_check(s, "col");
        check("col_flags", {hz.d_flush, hz.e_flush, hz.m_flush, hz.f_stall, hz.e_stall, hz.mdu_abort}, 6'b111001);
        tick(s);
        s = idle();
        drive_check(s, "col_after");
        check("col_abort_gone", hz.mdu_abort, 1'b0);
        check("col_flush_cnt", hz.flush_cnt, PERF_EN ? 32'd1 : 32'd0);
        tick(s);

        // Branch while waiting on the MDU.
        s = idle(); s.start = 1; step(s, "bw_enter"); step(s, "bw_wait");
        s.br = 1;
        drive_check(s, "bw_branch");
        check("bw_abort", hz.mdu_abort, 1'b1);
        tick(s);
        s = idle(); step(s, "bw_after");

        // Reset mid-MDU_WAIT.
        s = idle(); s.start = 1; step(s, "rw_enter"); step(s, "rw_wait");
        s.rst = 1;
        drive_check(s, "rw_reset");
        check("rw_quiet", {hz.e_stall, hz.m_flush, hz.mdu_abort}, 3'b000);
        tick(s);
        s = idle();
        drive_check(s, "rw_after");
        check("rw_run", {hz.e_stall, hz.mdu_abort}, 2'b00);
        tick(s);

        // Randomized traffic on narrow register indices to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            s.d_rs  = 5'($urandom_range(0, 3)); s.d_rt = 5'($urandom_range(0, 3));
            s.e_rs  = 5'($urandom_range(0, 3)); s.e_rt = 5'($urandom_range(0, 3));
            s.e_wa  = 5'($urandom_range(0, 3)); s.m_wa = 5'($urandom_range(0, 3));
            s.w_wa  = 5'($urandom_range(0, 3));
            s.e_we  = 1'($urandom_range(0, 3) != 0); s.e_load = 1'($urandom_range(0, 1));
            s.m_we  = 1'($urandom_range(0, 1));      s.w_we   = 1'($urandom_range(0, 1));
            s.br    = 1'($urandom_range(0, 7) == 0);
            s.start = 1'($urandom_range(0, 3) == 0);
            s.done  = 1'($urandom_range(0, 3) == 0);
            s.rst   = 1'($urandom_range(0, 99) == 0);
            step(s, "rnd");
        end

        // Saturation on the 3-bit instance: 6 stalls reach all-ones-1, 3 more stick at all-ones.
        s = idle(); s.rst = 1; step(s, "sat_rst");
        sz.e_mdu_start = 1'b1;
        s = idle();
        for (int c = 0; c < 6; c++) step(s, "sat_fill");
        check("sat_preload", sz.stall_cnt, PERF_EN ? 3'd6 : 3'd0);
        for (int c = 0; c < 3; c++) step(s, "sat_more");
        check("sat_allones", sz.stall_cnt, PERF_EN ? 3'd7 : 3'd0);
        check("sat_stalling", sz.f_stall, 1'b1);
        sz.e_mdu_start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter PERF_W, default 32, width of each performance counter.
REQ-002 clock  in  1  rising-edge clock; clock clock.
REQ-003 reset  in  1  reset reset, asynchronous, active-high.
REQ-004 d_rs, d_rt  in  5 each  source register addresses of the instruction in Decode.
REQ-005 e_rs, e_rt  in  5 each  source register addresses of the instruction in Execute.
REQ-006 e_rf_wa, e_rf_we, e_load  in  5/1/1  Execute destination, write enable, instruction-is-load flag.
REQ-007 m_rf_wa, m_rf_we  in  5/1  Memory-stage destination and write enable.
REQ-008 w_rf_wa, w_rf_we  in  5/1  Writeback-stage destination and write enable.
REQ-009 m_branch_taken  in  1  branch resolved taken in Memory stage.
REQ-010 e_mdu_start, mdu_done  in  1/1  multi-cycle multiply/divide start (Execute) and completion.
REQ-011 f_stall, d_stall, e_stall  out  1 each  hold the fetch, decode and execute registers.
REQ-012 d_flush, e_flush, m_flush  out  1 each  load a bubble into the decode, execute and memory registers.
REQ-013 fwd_a_e, fwd_b_e  out  2 each  ALU operand A/B forward select.
REQ-014 mdu_abort  out  1  one-cycle kill of an in-flight MDU operation.
REQ-015 stall_cnt, flush_cnt  out  PERF_W each  performance counters.

Function
REQ-016 fwd_a_e SHALL be 2'b10 if m_rf_we, m_rf_wa!=0 and m_rf_wa==e_rs; else 2'b01 if the same test passes for w_rf_*; else 2'b00. It is combinational, and Memory wins over Writeback. fwd_b_e SHALL use e_rt in the same way.
REQ-017 A load-use hazard exists when e_load, e_rf_we and e_rf_wa!=0 hold and e_rf_wa equals d_rs or d_rt. It is evaluated only in state RUN.
REQ-018 On a load-use hazard, f_stall=d_stall=1 and e_flush=1 for exactly that cycle. There is a one-cycle penalty and no state change.
REQ-019 When m_branch_taken=1, d_flush=e_flush=m_flush=1 and all stalls are 0 in that cycle. The branch overrides load-use and MDU stalls.
REQ-020 The FSM has states RUN and MDU_WAIT.
REQ-021 RUN to MDU_WAIT occurs on e_mdu_start & !mdu_done & !m_branch_taken. In that cycle f_stall=d_stall=e_stall=1 and m_flush=1.
REQ-022 In MDU_WAIT with !mdu_done, f_stall=d_stall=e_stall=1 and m_flush=1.
REQ-023 In MDU_WAIT with mdu_done, all stalls and flushes are 0 and the next state is RUN. The MDU instruction advances at that edge.
REQ-024 In RUN, e_mdu_start together with mdu_done (zero-latency completion) SHALL cause no stall and leave the state in RUN.
REQ-025 If m_branch_taken coincides with e_mdu_start in RUN, or occurs in MDU_WAIT: mdu_abort=1 for one cycle, REQ-019 flushes apply, and the next state is RUN.
REQ-026 mdu_abort SHALL be 0 in all other cycles.
REQ-027 stall_cnt SHALL increment by 1 on each clock with f_stall=1.
REQ-028 flush_cnt SHALL increment by 1 on each clock with m_branch_taken=1.
REQ-029 Both counters saturate at all-ones; they do not wrap.

Reset
REQ-030 While reset=1, the state is RUN, the counters are 0, all stall, flush and mdu_abort outputs are 0, and fwd_a_e=fwd_b_e=2'b00.
REQ-031 Reset asserted in MDU_WAIT SHALL return the FSM to RUN asynchronously, with no mdu_abort pulse.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: stall_cnt and flush_cnt are implemented per REQ-027 to REQ-029.
REQ-033 Macro not defined: both counter outputs are tied to 0, no counter flops exist, and all other behaviour is unchanged.

Structure
REQ-034 pipeline_pkg SHALL hold fwd_sel_t (FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10) and hazard_state_t (RUN, MDU_WAIT).
REQ-035 Sub-module hazard_perf_counter (PERF_W-wide saturating counter with increment enable) SHALL be instantiated twice under HAZARD_PERF_CNT_EN.

Verification
REQ-036 Forwarding: e_rs=5, m_rf_wa=5/we=1, w_rf_wa=5/we=1 -> fwd_a_e=10. With m_rf_we=0 -> 01. With e_rs=0 and both matching -> 00.
REQ-037 Load-use: e_load=1, e_rf_wa=8, d_rt=8 -> one cycle of f_stall=d_stall=e_flush=1, then all 0 once E holds the bubble.
REQ-038 MDU: e_mdu_start in cycle 0, mdu_done in cycle 4 -> e_stall=1 for cycles 0-3 and 0 in cycle 4, state RUN in cycle 5, stall_cnt=4.
REQ-039 Collision: e_mdu_start, m_branch_taken and a load-use hazard in the same cycle -> flushes D/E/M, no stalls, mdu_abort=1, state RUN, flush_cnt=1.
REQ-040 Reset mid-MDU_WAIT -> all outputs 0 immediately, state RUN, counters 0. Saturation: preload to all-ones -1, stall 3 cycles -> stall_cnt all-ones.
